serial_cmd_engine: RTL and testbench
====================================

Name: serial_cmd_engine

Overview:
Parametrised UART command processor that sits between the uart rx/tx pair and the trigger logic. It decodes single-byte opcodes followed by argument bytes and holds an indexed bank of 8-bit config registers. It drives PLL dynamic phase stepping with selectable counter, direction and step count, and pulses clkswitch. It snapshots and streams N histogram channels of configurable width, least-significant byte first.

Parameters:
NHIST, 4, number of histogram channels
HIST_W, 32, bits per histogram channel; must be a multiple of 8 and at most 64
NREG, 8, number of 8-bit config registers (2..256)
FW_VERSION, 8'd3, byte returned by opcode 0x00
SCAN_HALF, 16, clk cycles per scanclk half-period
TIMEOUT_CYCLES, 1000000, argument-wait timeout (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rxReady  in  1  one-cycle strobe: rxData valid
rxData  in  8  received byte
txBusy  in  1  transmitter busy
txStart  out  1  one-cycle strobe: send txData
txData  out  8  byte to send
cfg_regs  out  NREG*8  config bank; reg i at [8i+7:8i]
enable_outputs  out  1  output-enable toggle state
clkswitch  out  1  PLL clock-switch request
phasecounterselect  out  3  PLL counter select
phaseupdown  out  1  1=up, 0=down
phasestep  out  1  PLL phasestep
scanclk  out  1  PLL scan clock
histos  in  NHIST*HIST_W  channel c at [c*HIST_W +: HIST_W]
resethist  out  1  one-cycle histogram clear pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: a single clock domain (clk). reset is synchronous and active-high.
- Reset values: state=IDLE. txStart, txData, cfg_regs, enable_outputs, clkswitch, phasestep, scanclk, resethist, busy and phasecounterselect all 0. phaseupdown=1.
- States: IDLE, ARGS, EXEC, TX_LOAD, TX_WAIT, CLKSW, PLL.
- IDLE: on rxReady, latch the opcode and clear the argument count. Go to ARGS if the opcode needs arguments, otherwise go to EXEC.
- ARGS: each rxReady stores one argument byte. Go to EXEC after the last byte. Other inputs are ignored.
- Opcodes (argument count in brackets):
  - 0x00 [0]: transmit FW_VERSION.
  - 0x01 [2]: idx, val. cfg_regs[idx]<=val. Ignored if idx>=NREG.
  - 0x02 [1]: idx. Transmit cfg_regs[idx], or 0x00 if idx>=NREG.
  - 0x03 [0]: toggle enable_outputs.
  - 0x04 [0]: clkswitch=1 for exactly 8 cycles, then return to IDLE.
  - 0x05 [2]: sel, n.
    - phasecounterselect=sel[2:0], phaseupdown=sel[7].
    - Performs n phase steps; n=0 is a no-op.
    - Each step: phasestep=1, scanclk toggles every SCAN_HALF cycles for 4 full periods, phasestep drops after the 3rd rising edge, and scanclk ends low.
  - 0x0A [0]: snapshot all histos into a buffer in EXEC; resethist=1 in that same cycle only. Transmit NHIST*HIST_W/8 bytes: channel 0 first, LSB first.
  - 0x0B [1]: ch. Snapshot and clear as 0x0A, but transmit only channel ch's HIST_W/8 bytes. If ch>=NHIST, transmit zeros and do not pulse resethist.
  - Any other opcode: return to IDLE, with no response and no side effects.
- Transmit handshake:
  - TX_LOAD waits for txBusy=0, drives txData and txStart=1 for one cycle, then goes to TX_WAIT.
  - TX_WAIT advances the byte index: back to TX_LOAD if bytes remain, otherwise to IDLE.
  - txStart is never high in two consecutive cycles.
- rxReady outside IDLE and ARGS is dropped.
- The histogram snapshot is taken once per command; histos changes during transmission do not affect the response.
- reset mid-operation aborts immediately to reset values, including scanclk=0 and phasestep=0.

Optional Feature:
CMD_TIMEOUT_EN
- Defined: a counter clears on entry to ARGS and on each rxReady. When it reaches TIMEOUT_CYCLES, discard the partial command and return to IDLE with no side effects.
- Not defined: ARGS waits indefinitely.

Decomposition:
- Package serial_cmd_pkg: opcode localparams (OP_VERSION, OP_WRREG, OP_RDREG, OP_TOGGLE_OE, OP_CLKSW, OP_PHASE, OP_HIST_ALL, OP_HIST_ONE), the state enum typedef, and a function returning the argument count per opcode.
- Sub-module pll_phase_stepper: owns scanclk, phasestep and the step counter, with a start/done handshake.

Test Plan:
- Reset, then send 0x00 -> exactly one txStart with txData=FW_VERSION; all outputs at reset values before the command.
- Send 0x01,0x02,0xA5 then 0x02,0x02 -> cfg_regs[23:16]=0xA5 and response 0xA5. Send 0x01,NREG,0x11 -> cfg_regs unchanged. Send 0x02,0xFF -> response 0x00.
- histos={32'h44332211,...,32'hDDCCBBAA} with NHIST=4, send 0x0A -> 16 bytes AA BB CC DD ... 11 22 33 44 in channel order. resethist is high for exactly 1 cycle. With txBusy held high for 50 cycles, no byte is lost.
- Send 0x05,0x83,0x02 -> phasecounterselect=3, phaseupdown=1, 2 phasestep pulses, 8 scanclk rising edges in total; busy low afterwards. Send 0x05,0x00,0x00 -> no scanclk activity.
- Send 0x04 -> clkswitch high for exactly 8 cycles. Assert reset during a 0x05 sequence -> scanclk=0 and phasestep=0 on the next cycle.
- With CMD_TIMEOUT_EN defined: send 0x01,0x03, then idle for TIMEOUT_CYCLES -> return to IDLE and cfg_regs unchanged. A following 0x00 is answered correctly.

Source files
------------

// File: rtl/serial_cmd_pkg.sv
// Shared opcodes, FSM state types and argument-count decode for serial_cmd_engine.
package serial_cmd_pkg;

  localparam logic [7:0] OP_VERSION    = 8'h00;
  localparam logic [7:0] OP_WRREG      = 8'h01;
  localparam logic [7:0] OP_RDREG      = 8'h02;
  localparam logic [7:0] OP_TOGGLE_OE  = 8'h03;
  localparam logic [7:0] OP_CLKSW      = 8'h04;
  localparam logic [7:0] OP_PHASE      = 8'h05;
  localparam logic [7:0] OP_HIST_ALL   = 8'h0A;
  localparam logic [7:0] OP_HIST_ONE   = 8'h0B;

  typedef enum logic [2:0] {
    StIdle,
    StArgs,
    StExec,
    StTxLoad,
    StTxWait,
    StClksw,
    StPll
  } state_e;

  typedef enum logic {
    StStepIdle,
    StStepRun
  } step_state_e;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WRREG, OP_PHASE:    arg_count = 2'd2;
      OP_RDREG, OP_HIST_ONE: arg_count = 2'd1;
      default:               arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pll_phase_stepper.sv
// Generates n PLL phase steps: each step holds phasestep through three scanclk rising
// edges and runs scanclk for four full periods, ending low. done pulses when finished.
module pll_phase_stepper
  import serial_cmd_pkg::*;
#(
  parameter int unsigned SCAN_HALF = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] nsteps_i,
  output logic       done_o,
  output logic       scanclk_o,
  output logic       phasestep_o
);

  localparam int unsigned HalfW = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;

  step_state_e      state_d, state_q;
  logic [HalfW-1:0] half_cnt_d, half_cnt_q;
  logic [2:0]       tog_cnt_d, tog_cnt_q;
  logic [7:0]       steps_d, steps_q;
  logic             scanclk_d, scanclk_q;
  logic             phasestep_d, phasestep_q;
  logic             done_d, done_q;

  always_comb begin
    state_d     = state_q;
    half_cnt_d  = half_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    steps_d     = steps_q;
    scanclk_d   = scanclk_q;
    phasestep_d = phasestep_q;
    done_d      = 1'b0;
    unique case (state_q)
      StStepIdle: begin
        if (start_i) begin
          if (nsteps_i == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StStepRun;
            steps_d     = nsteps_i;
            half_cnt_d  = '0;
            tog_cnt_d   = '0;
            scanclk_d   = 1'b0;
            phasestep_d = 1'b1;
          end
        end
      end
      StStepRun: begin
        if (half_cnt_q == HalfW'(SCAN_HALF - 1)) begin
          half_cnt_d = '0;
          scanclk_d  = ~scanclk_q;
          tog_cnt_d  = tog_cnt_q + 3'd1;
          // Toggle 4 is the third rising edge of the step.
          if (tog_cnt_q == 3'd4) phasestep_d = 1'b0;
          if (tog_cnt_q == 3'd7) begin
            steps_d = steps_q - 8'd1;
            if (steps_q == 8'd1) begin
              state_d = StStepIdle;
              done_d  = 1'b1;
            end else begin
              phasestep_d = 1'b1;
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + HalfW'(1);
        end
      end
      default: state_d = StStepIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StStepIdle;
      half_cnt_q  <= '0;
      tog_cnt_q   <= '0;
      steps_q     <= '0;
      scanclk_q   <= 1'b0;
      phasestep_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_cnt_q  <= half_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      steps_q     <= steps_d;
      scanclk_q   <= scanclk_d;
      phasestep_q <= phasestep_d;
      done_q      <= done_d;
    end
  end

  assign done_o      = done_q;
  assign scanclk_o   = scanclk_q;
  assign phasestep_o = phasestep_q;

endmodule

// File: rtl/serial_cmd_engine.sv
// UART byte-command processor: config register bank, PLL phase stepping, clkswitch and
// histogram readout. Define CMD_TIMEOUT_EN to abandon stalled argument reception.
module serial_cmd_engine
  import serial_cmd_pkg::*;
#(
  parameter int unsigned NHIST          = 4,
  parameter int unsigned HIST_W         = 32,
  parameter int unsigned NREG           = 8,
  parameter logic [7:0]  FW_VERSION     = 8'd3,
  parameter int unsigned SCAN_HALF      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rxReady,
  input  logic [7:0]              rxData,
  input  logic                    txBusy,
  output logic                    txStart,
  output logic [7:0]              txData,
  output logic [NREG*8-1:0]       cfg_regs,
  output logic                    enable_outputs,
  output logic                    clkswitch,
  output logic [2:0]              phasecounterselect,
  output logic                    phaseupdown,
  output logic                    phasestep,
  output logic                    scanclk,
  input  logic [NHIST*HIST_W-1:0] histos,
  output logic                    resethist,
  output logic                    busy
);

  localparam int unsigned BufW     = NHIST * HIST_W;
  localparam int unsigned TotBytes = BufW / 8;
  localparam int unsigned IdxW     = $clog2(TotBytes + 1);

  state_e               state_d, state_q;
  logic [7:0]           opcode_d, opcode_q;
  logic [1:0][7:0]      args_d, args_q;
  logic [1:0]           arg_cnt_d, arg_cnt_q;
  logic [NREG-1:0][7:0] cfg_d, cfg_q;
  logic                 enable_d, enable_q;
  logic                 clksw_d, clksw_q;
  logic [2:0]           clksw_cnt_d, clksw_cnt_q;
  logic [2:0]           pcs_d, pcs_q;
  logic                 updown_d, updown_q;
  logic                 txstart_d, txstart_q;
  logic [7:0]           txdata_d, txdata_q;
  logic [BufW-1:0]      tx_buf_d, tx_buf_q;
  logic [IdxW-1:0]      tx_len_d, tx_len_q;
  logic [IdxW-1:0]      tx_idx_d, tx_idx_q;
  logic                 step_start, step_done;
  logic                 hist_clr;

`ifdef CMD_TIMEOUT_EN
  logic [31:0] to_cnt_d, to_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    args_d      = args_q;
    arg_cnt_d   = arg_cnt_q;
    cfg_d       = cfg_q;
    enable_d    = enable_q;
    clksw_d     = clksw_q;
    clksw_cnt_d = clksw_cnt_q;
    pcs_d       = pcs_q;
    updown_d    = updown_q;
    txstart_d   = 1'b0;
    txdata_d    = txdata_q;
    tx_buf_d    = tx_buf_q;
    tx_len_d    = tx_len_q;
    tx_idx_d    = tx_idx_q;
    step_start  = 1'b0;
    hist_clr    = 1'b0;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d = (state_q == StArgs && !rxReady) ? to_cnt_q + 32'd1 : 32'd0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rxReady) begin
          opcode_d  = rxData;
          arg_cnt_d = 2'd0;
          state_d   = (arg_count(rxData) != 2'd0) ? StArgs : StExec;
        end
      end
      StArgs: begin
        if (rxReady) begin
          args_d[arg_cnt_q[0]] = rxData;
          arg_cnt_d            = arg_cnt_q + 2'd1;
          if (arg_cnt_q + 2'd1 == arg_count(opcode_q)) state_d = StExec;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
        end
`endif
      end
      StExec: begin
        tx_idx_d = '0;
        state_d  = StIdle;
        case (opcode_q)
          OP_VERSION: begin
            tx_buf_d      = '0;
            tx_buf_d[7:0] = FW_VERSION;
            tx_len_d      = IdxW'(1);
            state_d       = StTxLoad;
          end
          OP_WRREG: begin
            for (int unsigned i = 0; i < NREG; i++) begin
              if (args_q[0] == 8'(i)) cfg_d[i] = args_q[1];
            end
          end
          OP_RDREG: begin
            tx_buf_d = '0;
            for (int unsigned i = 0; i < NREG; i++) begin
              if (args_q[0] == 8'(i)) tx_buf_d[7:0] = cfg_q[i];
            end
            tx_len_d = IdxW'(1);
            state_d  = StTxLoad;
          end
          OP_TOGGLE_OE: enable_d = ~enable_q;
          OP_CLKSW: begin
            clksw_d     = 1'b1;
            clksw_cnt_d = 3'd0;
            state_d     = StClksw;
          end
          OP_PHASE: begin
            pcs_d      = args_q[0][2:0];
            updown_d   = args_q[0][7];
            step_start = 1'b1;
            state_d    = StPll;
          end
          OP_HIST_ALL: begin
            tx_buf_d = histos;
            hist_clr = 1'b1;
            tx_len_d = IdxW'(TotBytes);
            state_d  = StTxLoad;
          end
          OP_HIST_ONE: begin
            // Out-of-range channel answers zeros and leaves the histograms alone.
            tx_buf_d = '0;
            for (int unsigned c = 0; c < NHIST; c++) begin
              if (args_q[0] == 8'(c)) begin
                tx_buf_d[HIST_W-1:0] = histos[c*HIST_W +: HIST_W];
                hist_clr             = 1'b1;
              end
            end
            tx_len_d = IdxW'(HIST_W / 8);
            state_d  = StTxLoad;
          end
          default: state_d = StIdle;
        endcase
      end
      StTxLoad: begin
        if (!txBusy) begin
          txstart_d = 1'b1;
          txdata_d  = tx_buf_q[{tx_idx_q, 3'b000} +: 8];
          state_d   = StTxWait;
        end
      end
      StTxWait: begin
        tx_idx_d = tx_idx_q + IdxW'(1);
        state_d  = (tx_idx_q + IdxW'(1) < tx_len_q) ? StTxLoad : StIdle;
      end
      StClksw: begin
        clksw_cnt_d = clksw_cnt_q + 3'd1;
        if (clksw_cnt_q == 3'd7) begin
          clksw_d = 1'b0;
          state_d = StIdle;
        end
      end
      StPll: begin
        if (step_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      opcode_q    <= '0;
      args_q      <= '0;
      arg_cnt_q   <= '0;
      cfg_q       <= '0;
      enable_q    <= 1'b0;
      clksw_q     <= 1'b0;
      clksw_cnt_q <= '0;
      pcs_q       <= '0;
      updown_q    <= 1'b1;
      txstart_q   <= 1'b0;
      txdata_q    <= '0;
      tx_buf_q    <= '0;
      tx_len_q    <= '0;
      tx_idx_q    <= '0;
      busy        <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      args_q      <= args_d;
      arg_cnt_q   <= arg_cnt_d;
      cfg_q       <= cfg_d;
      enable_q    <= enable_d;
      clksw_q     <= clksw_d;
      clksw_cnt_q <= clksw_cnt_d;
      pcs_q       <= pcs_d;
      updown_q    <= updown_d;
      txstart_q   <= txstart_d;
      txdata_q    <= txdata_d;
      tx_buf_q    <= tx_buf_d;
      tx_len_q    <= tx_len_d;
      tx_idx_q    <= tx_idx_d;
      busy        <= (state_d != StIdle);
`ifdef CMD_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  pll_phase_stepper #(
    .SCAN_HALF(SCAN_HALF)
  ) u_stepper (
    .clk        (clk),
    .reset      (reset),
    .start_i    (step_start),
    .nsteps_i   (args_q[1]),
    .done_o     (step_done),
    .scanclk_o  (scanclk),
    .phasestep_o(phasestep)
  );

  // Clear pulse coincides with the snapshot edge so no counts fall between them.
  assign resethist          = hist_clr;
  assign txStart            = txstart_q;
  assign txData             = txdata_q;
  assign cfg_regs           = cfg_q;
  assign enable_outputs     = enable_q;
  assign clkswitch          = clksw_q;
  assign phasecounterselect = pcs_q;
  assign phaseupdown        = updown_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Directed self-checking bench for serial_cmd_engine (NHIST=4, HIST_W=32, NREG=8).
module tb_serial_cmd_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rxReady = 1'b0;
  logic [7:0]   rxData = 8'h00;
  logic         txBusy = 1'b0;
  logic         txStart;
  logic [7:0]   txData;
  logic [63:0]  cfg_regs;
  logic         enable_outputs, clkswitch, phaseupdown, phasestep, scanclk, resethist, busy;
  logic [2:0]   phasecounterselect;
  logic [127:0] histos = '0;

  int errors = 0;
  int checks = 0;

  serial_cmd_engine #(
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rxReady           (rxReady),
    .rxData            (rxData),
    .txBusy            (txBusy),
    .txStart           (txStart),
    .txData            (txData),
    .cfg_regs          (cfg_regs),
    .enable_outputs    (enable_outputs),
    .clkswitch         (clkswitch),
    .phasecounterselect(phasecounterselect),
    .phaseupdown       (phaseupdown),
    .phasestep         (phasestep),
    .scanclk           (scanclk),
    .histos            (histos),
    .resethist         (resethist),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled 1 time unit after each rising edge.
  logic [7:0] tx_q[$];
  int n_start = 0, n_double = 0, n_rh = 0, n_clksw = 0;
  int n_sc_rise = 0, n_ps_rise = 0, n_sc_rise_ps = 0;
  logic prev_sc = 1'b0, prev_ps = 1'b0, prev_ts = 1'b0;

  always @(posedge clk) begin
    #1;
    if (txStart) begin
      n_start++;
      tx_q.push_back(txData);
      if (prev_ts) n_double++;
    end
    if (resethist) n_rh++;
    if (clkswitch) n_clksw++;
    if (!prev_sc && scanclk) begin
      n_sc_rise++;
      if (prev_ps) n_sc_rise_ps++;
    end
    if (!prev_ps && phasestep) n_ps_rise++;
    prev_sc = scanclk;
    prev_ps = phasestep;
    prev_ts = txStart;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rxReady = 1'b1;
    rxData  = b;
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({txStart, txData, enable_outputs, clkswitch, phasestep, scanclk, resethist, busy}
        !== 14'h0) begin
      errors++;
      $display("FAIL reset_outs: txS=%b txD=%h oe=%b csw=%b ps=%b sc=%b rh=%b busy=%b, required 0",
               txStart, txData, enable_outputs, clkswitch, phasestep, scanclk, resethist, busy);
    end
    checks++;
    if (cfg_regs !== 64'h0) begin
      errors++;
      $display("FAIL reset_cfg: got %h required 0", cfg_regs);
    end
    checks++;
    if (phasecounterselect !== 3'd0 || phaseupdown !== 1'b1) begin
      errors++;
      $display("FAIL reset_pll: sel=%0d updown=%b required sel=0 updown=1",
               phasecounterselect, phaseupdown);
    end
  endtask

  task automatic expect_bytes(input string name, input logic [7:0] exp[$], input int n0);
    checks++;
    if (tx_q.size() !== n0 + exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes required %0d", name, tx_q.size() - n0, exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (tx_q[n0+i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: got %h required %h", name, i, tx_q[n0+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_version();
    int n0 = tx_q.size();
    send(8'h00);
    wait_idle(50, "version_idle");
    expect_bytes("version", '{8'h03}, n0);
  endtask

  task automatic test_regs();
    int n0;
    send(8'h01); send(8'h02); send(8'hA5);
    wait_idle(50, "wrreg_idle");
    checks++;
    if (cfg_regs !== 64'h0000_0000_00A5_0000) begin
      errors++;
      $display("FAIL wrreg: got %h required 00000000_00a50000", cfg_regs);
    end
    n0 = tx_q.size();
    send(8'h02); send(8'h02);
    wait_idle(50, "rdreg_idle");
    expect_bytes("rdreg", '{8'hA5}, n0);
    send(8'h01); send(8'h08); send(8'h11);
    wait_idle(50, "wrreg_oor_idle");
    checks++;
    if (cfg_regs !== 64'h0000_0000_00A5_0000) begin
      errors++;
      $display("FAIL wrreg_oor: got %h required 00000000_00a50000", cfg_regs);
    end
    n0 = tx_q.size();
    send(8'h02); send(8'hFF);
    wait_idle(50, "rdreg_oor_idle");
    expect_bytes("rdreg_oor", '{8'h00}, n0);
    send(8'h03);
    wait_idle(50, "toggle_idle");
    checks++;
    if (enable_outputs !== 1'b1) begin
      errors++;
      $display("FAIL toggle_on: got %b required 1", enable_outputs);
    end
    send(8'h03);
    wait_idle(50, "toggle2_idle");
    checks++;
    if (enable_outputs !== 1'b0) begin
      errors++;
      $display("FAIL toggle_off: got %b required 0", enable_outputs);
    end
  endtask

  task automatic test_hist_all();
    int n0 = tx_q.size();
    int s0 = n_start;
    int r0 = n_rh;
    histos = {32'h44332211, 32'h0FEEDDCC, 32'h88776655, 32'hDDCCBBAA};
    txBusy = 1'b1;
    send(8'h0A);
    repeat (50) @(negedge clk);
    checks++;
    if (n_start !== s0) begin
      errors++;
      $display("FAIL hist_busy_hold: got %0d starts required 0", n_start - s0);
    end
    histos = '1;
    txBusy = 1'b0;
    wait_idle(200, "hist_all_idle");
    expect_bytes("hist_all", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88,
                               8'hCC, 8'hDD, 8'hEE, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44}, n0);
    checks++;
    if (n_rh - r0 !== 1) begin
      errors++;
      $display("FAIL hist_all_resethist: got %0d cycles required 1", n_rh - r0);
    end
  endtask

  task automatic test_hist_one();
    int n0 = tx_q.size();
    int r0 = n_rh;
    histos = {32'h44332211, 32'h0FEEDDCC, 32'h88776655, 32'hDDCCBBAA};
    send(8'h0B); send(8'h02);
    wait_idle(100, "hist_one_idle");
    expect_bytes("hist_one", '{8'hCC, 8'hDD, 8'hEE, 8'h0F}, n0);
    checks++;
    if (n_rh - r0 !== 1) begin
      errors++;
      $display("FAIL hist_one_resethist: got %0d cycles required 1", n_rh - r0);
    end
    n0 = tx_q.size();
    r0 = n_rh;
    send(8'h0B); send(8'h07);
    wait_idle(100, "hist_oor_idle");
    expect_bytes("hist_oor", '{8'h00, 8'h00, 8'h00, 8'h00}, n0);
    checks++;
    if (n_rh - r0 !== 0) begin
      errors++;
      $display("FAIL hist_oor_resethist: got %0d cycles required 0", n_rh - r0);
    end
  endtask

  task automatic test_phase();
    int sc0 = n_sc_rise;
    int ps0 = n_ps_rise;
    int sp0 = n_sc_rise_ps;
    send(8'h05); send(8'h83); send(8'h02);
    wait_idle(1000, "phase_idle");
    checks++;
    if (phasecounterselect !== 3'd3 || phaseupdown !== 1'b1) begin
      errors++;
      $display("FAIL phase_sel: sel=%0d updown=%b required sel=3 updown=1",
               phasecounterselect, phaseupdown);
    end
    checks++;
    if (n_ps_rise - ps0 !== 2) begin
      errors++;
      $display("FAIL phase_steps: got %0d required 2", n_ps_rise - ps0);
    end
    checks++;
    if (n_sc_rise - sc0 !== 8) begin
      errors++;
      $display("FAIL phase_scanclk: got %0d rises required 8", n_sc_rise - sc0);
    end
    checks++;
    if (n_sc_rise_ps - sp0 !== 6) begin
      errors++;
      $display("FAIL phase_ps_width: got %0d rises under phasestep required 6",
               n_sc_rise_ps - sp0);
    end
    checks++;
    if (scanclk !== 1'b0 || phasestep !== 1'b0) begin
      errors++;
      $display("FAIL phase_end: sc=%b ps=%b required 0 0", scanclk, phasestep);
    end
    sc0 = n_sc_rise;
    send(8'h05); send(8'h00); send(8'h00);
    wait_idle(100, "phase0_idle");
    checks++;
    if (n_sc_rise - sc0 !== 0 || phasecounterselect !== 3'd0 || phaseupdown !== 1'b0) begin
      errors++;
      $display("FAIL phase_zero: rises=%0d sel=%0d updown=%b required 0 0 0",
               n_sc_rise - sc0, phasecounterselect, phaseupdown);
    end
  endtask

  task automatic test_clksw();
    int c0 = n_clksw;
    send(8'h04);
    wait_idle(100, "clksw_idle");
    checks++;
    if (n_clksw - c0 !== 8) begin
      errors++;
      $display("FAIL clksw: got %0d cycles required 8", n_clksw - c0);
    end
  endtask

  task automatic test_unknown();
    int n0 = tx_q.size();
    send(8'h77);
    wait_idle(50, "unknown_idle");
    checks++;
    if (tx_q.size() !== n0 || cfg_regs !== 64'h0000_0000_00A5_0000) begin
      errors++;
      $display("FAIL unknown: bytes=%0d cfg=%h required 0 bytes, cfg 00000000_00a50000",
               tx_q.size() - n0, cfg_regs);
    end
  endtask

  task automatic test_args_wait();
    int n0;
    send(8'h01); send(8'h03);
`ifdef CMD_TIMEOUT_EN
    wait_idle(200, "timeout_idle");
    checks++;
    if (cfg_regs !== 64'h0000_0000_00A5_0000) begin
      errors++;
      $display("FAIL timeout_cfg: got %h required 00000000_00a50000", cfg_regs);
    end
    n0 = tx_q.size();
    send(8'h00);
    wait_idle(50, "timeout_version_idle");
    expect_bytes("timeout_version", '{8'h03}, n0);
`else
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL args_wait: busy=%b required 1", busy);
    end
    send(8'h44);
    wait_idle(50, "args_wait_idle");
    checks++;
    if (cfg_regs !== 64'h0000_0000_44A5_0000) begin
      errors++;
      $display("FAIL args_wait_cfg: got %h required 00000000_44a50000", cfg_regs);
    end
    n0 = tx_q.size();
    checks++;
    if (n0 !== n_start) begin
      errors++;
      $display("FAIL tx_log: got %0d bytes required %0d", n0, n_start);
    end
`endif
  endtask

  task automatic test_reset_mid_phase();
    int sc0 = n_sc_rise;
    send(8'h05); send(8'h01); send(8'h05);
    repeat (40) @(negedge clk);
    checks++;
    if (n_sc_rise - sc0 < 1 || phasestep !== 1'b1) begin
      errors++;
      $display("FAIL midphase_active: rises=%0d ps=%b required >=1 and 1",
               n_sc_rise - sc0, phasestep);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (scanclk !== 1'b0 || phasestep !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midphase_reset: sc=%b ps=%b busy=%b required 0 0 0",
               scanclk, phasestep, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cfg_regs !== 64'h0 || phaseupdown !== 1'b1) begin
      errors++;
      $display("FAIL midphase_regs: cfg=%h updown=%b required 0 and 1", cfg_regs, phaseupdown);
    end
  endtask

  initial begin
    test_reset();
    test_version();
    test_regs();
    test_hist_all();
    test_hist_one();
    test_phase();
    test_clksw();
    test_unknown();
    test_args_wait();
    test_reset_mid_phase();
    checks++;
    if (n_double !== 0) begin
      errors++;
      $display("FAIL txstart_back_to_back: got %0d required 0", n_double);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
